// File: rtl/conv_sched_pkg.sv
// Shared FSM state type and constants for the ADC-to-DAC conversion scheduler.
package conv_sched_pkg;

    localparam int DAC_W     = 16;
    localparam int AVG_CNT   = 4;
    localparam int AVG_SHIFT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_START,
        ST_CONV,
        ST_DELIV
    } state_t;

endpackage

// File: rtl/conv_scheduler_tick_gen.sv
// Sample-rate divider: counts 0..CLK_DIV-1 while enabled and flags the wrap cycle.
module tick_gen #(
    parameter int CLK_DIV = 36000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] r_count;
    logic          w_wrap;

    assign w_wrap = (r_count == CW'(CLK_DIV - 1));
    assign o_tick = i_enable && w_wrap;

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_enable) begin
            r_count <= '0;
        end else if (w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/conv_scheduler.sv
// Paces SA-ADC conversions at CLK_DIV and forwards each result to the DAC shift-out.
// Optional CONV_SCHED_AVG_EN: four conversions per tick, their mean is delivered.
module conv_scheduler
    import conv_sched_pkg::*;
#(
    parameter int CLK_DIV = 36000,
    parameter int TIMEOUT = 1024,
    parameter int DATA_W  = 14
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic              clear_i,
    output logic              adc_start_o,
    input  logic [DATA_W-1:0] adc_data_i,
    input  logic              adc_rdy_i,
    output logic [DAC_W-1:0]  dac_data_o,
    output logic              dac_rdy_o,
    input  logic              dac_busy_i,
    output logic              overrun_o,
    output logic              timeout_o
);

    localparam int TO_W = $clog2(TIMEOUT);

    state_t             r_state;
    state_t             w_next;
    logic               r_pend;
    logic [TO_W-1:0]    r_tocnt;
    logic [DATA_W-1:0]  r_sample;
    logic [DAC_W-1:0]   r_dac_data;
    logic               r_dac_rdy;
    logic               r_overrun;
    logic               r_timeout;

    logic               w_tick;
    logic               w_consume;
    logic               w_capture;
    logic               w_deliver;
    logic               w_timeout_set;
    logic               w_overrun_set;
    logic [DATA_W-1:0]  w_deliver_data;
    logic [DATA_W-1:0]  w_result;
    logic               w_last_sub;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .i_clk    (clk_i),
        .i_reset  (reset_i),
        .i_enable (enable_i),
        .o_tick   (w_tick)
    );

`ifdef CONV_SCHED_AVG_EN
    logic [AVG_SHIFT-1:0]       r_sub;
    logic [DATA_W+AVG_SHIFT-1:0] r_sum;
    logic [DATA_W+AVG_SHIFT-1:0] w_sum_next;

    assign w_sum_next = r_sum + {{AVG_SHIFT{1'b0}}, adc_data_i};
    assign w_result   = w_sum_next[AVG_SHIFT +: DATA_W];
    assign w_last_sub = (r_sub == AVG_SHIFT'(AVG_CNT - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i || w_consume) begin
            r_sub <= '0;
            r_sum <= '0;
        end else if (w_capture && !w_last_sub) begin
            r_sub <= r_sub + 1'b1;
            r_sum <= w_sum_next;
        end
    end
`else
    assign w_result   = adc_data_i;
    assign w_last_sub = 1'b1;
`endif

    assign w_overrun_set = w_tick && r_pend && !w_consume;

    // A final result that finds the DAC idle is strobed straight from CONV, giving
    // the one-cycle adc_rdy -> dac_rdy latency; DELIV only holds a blocked sample.
    always_comb begin
        w_next         = r_state;
        w_consume      = 1'b0;
        w_capture      = 1'b0;
        w_deliver      = 1'b0;
        w_timeout_set  = 1'b0;
        w_deliver_data = r_sample;
        if (!enable_i) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_next = ST_WAIT;
                ST_WAIT: begin
                    if (r_pend || w_tick) begin
                        w_consume = 1'b1;
                        w_next    = ST_START;
                    end
                end
                ST_START: w_next = ST_CONV;
                ST_CONV: begin
                    if (adc_rdy_i) begin
                        w_capture = 1'b1;
                        if (!w_last_sub) begin
                            w_next = ST_START;
                        end else if (!dac_busy_i) begin
                            w_deliver      = 1'b1;
                            w_deliver_data = w_result;
                            w_next         = ST_WAIT;
                        end else begin
                            w_next = ST_DELIV;
                        end
                    end else if (r_tocnt == TO_W'(TIMEOUT - 1)) begin
                        w_timeout_set = 1'b1;
                        w_next        = ST_WAIT;
                    end
                end
                ST_DELIV: begin
                    if (!dac_busy_i) begin
                        w_deliver = 1'b1;
                        w_next    = ST_WAIT;
                    end
                end
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= ST_IDLE;
            r_pend     <= 1'b0;
            r_tocnt    <= '0;
            r_sample   <= '0;
            r_dac_data <= '0;
            r_dac_rdy  <= 1'b0;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pend    <= enable_i && (w_tick ? (r_pend || !w_consume) : (r_pend && !w_consume));
            r_dac_rdy <= w_deliver;
            r_overrun <= w_overrun_set || (r_overrun && !clear_i);
            r_timeout <= w_timeout_set || (r_timeout && !clear_i);
            if (r_state == ST_START) begin
                r_tocnt <= '0;
            end else if (r_state == ST_CONV) begin
                r_tocnt <= r_tocnt + 1'b1;
            end
            if (w_capture) begin
                r_sample <= w_result;
            end
            if (w_deliver) begin
                r_dac_data <= DAC_W'(w_deliver_data);
            end
        end
    end

    assign adc_start_o = (r_state == ST_START);
    assign dac_data_o  = r_dac_data;
    assign dac_rdy_o   = r_dac_rdy;
    assign overrun_o   = r_overrun;
    assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_conv_scheduler.sv
// Self-checking bench for conv_scheduler: ADC response model plus a delivery scoreboard.
module tb_conv_scheduler;
    import conv_sched_pkg::*;

    localparam int CLK_DIV = 100;
    localparam int TIMEOUT = 50;
    localparam int DATA_W  = 14;
    localparam int ADC_LAT = 20;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              enable_i = 1'b0;
    logic              clear_i = 1'b0;
    logic              adc_start_o;
    logic [DATA_W-1:0] adc_data_i = '0;
    logic              adc_rdy_i = 1'b0;
    logic [15:0]       dac_data_o;
    logic              dac_rdy_o;
    logic              dac_busy_i = 1'b0;
    logic              overrun_o;
    logic              timeout_o;

    always #5 clk = ~clk;

    conv_scheduler #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT), .DATA_W(DATA_W)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .enable_i    (enable_i),
        .clear_i     (clear_i),
        .adc_start_o (adc_start_o),
        .adc_data_i  (adc_data_i),
        .adc_rdy_i   (adc_rdy_i),
        .dac_data_o  (dac_data_o),
        .dac_rdy_o   (dac_rdy_o),
        .dac_busy_i  (dac_busy_i),
        .overrun_o   (overrun_o),
        .timeout_o   (timeout_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [15:0]       expQ[$];
    logic [DATA_W-1:0] adcValues[$];
    logic [DATA_W-1:0] adcDefault = 14'h1ABC;
    logic [DATA_W-1:0] adcVal;
    bit  adcRespond = 1'b1;
    bit  expectDelivery = 1'b1;
    int  adcCountdown = 0;
    int  rdySeen = 0;
    int  startSeen = 0;
    int  lastStart = 0;
    int  avgSum = 0;
    int  avgN = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitStart(input int maxCyc, output bit found, output int at);
        found = 1'b0;
        at = -1;
        for (int i = 0; i < maxCyc; i++) begin
            step();
            if (adc_start_o === 1'b1) begin
                found = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic waitDacRdy(input int maxCyc, output bit found, output int at);
        found = 1'b0;
        at = -1;
        for (int i = 0; i < maxCyc; i++) begin
            step();
            if (dac_rdy_o === 1'b1) begin
                found = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    // ADC model: strobes a result ADC_LAT cycles after each observed start pulse
    initial begin
        forever begin
            step();
            adc_rdy_i = 1'b0;
            if (adcCountdown > 0) begin
                adcCountdown--;
                if (adcCountdown == 0) begin
                    if (adcValues.size() > 0) adcVal = adcValues.pop_front();
                    else adcVal = adcDefault;
                    adc_data_i = adcVal;
                    adc_rdy_i  = 1'b1;
                    if (expectDelivery) begin
`ifdef CONV_SCHED_AVG_EN
                        avgSum += int'(adcVal);
                        avgN++;
                        if (avgN == AVG_CNT) begin
                            expQ.push_back(16'(avgSum >> AVG_SHIFT));
                            avgSum = 0;
                            avgN = 0;
                        end
`else
                        expQ.push_back(16'(adcVal));
`endif
                    end
                end
            end
            if (adc_start_o === 1'b1 && adcRespond) adcCountdown = ADC_LAT;
        end
    end

    // Scoreboard: every dac strobe must match the oldest expected sample
    initial begin
        logic [15:0] prevData;
        logic        prevReset;
        logic [15:0] expData;
        prevData  = 16'h0;
        prevReset = 1'b1;
        forever begin
            @(negedge clk);
            if (adc_start_o === 1'b1) startSeen++;
            if (dac_rdy_o === 1'b1) begin
                rdySeen++;
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_dac_rdy: got data %h, expected no strobe", dac_data_o);
                end else begin
                    expData = expQ.pop_front();
                    if (dac_data_o !== expData) begin
                        failures++;
                        $display("[TB] FAIL dac_data: got %h, expected %h", dac_data_o, expData);
                    end
                end
            end
            if (dac_data_o !== prevData) begin
                checks++;
                if (dac_rdy_o !== 1'b1 && !prevReset) begin
                    failures++;
                    $display("[TB] FAIL dac_data_hold: changed to %h without dac_rdy_o", dac_data_o);
                end
            end
            prevData  = dac_data_o;
            prevReset = reset_i;
        end
    end

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) step();
        reset_i = 1'b0;
        step();
        checks += 6;
        if (adc_start_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_start: got %b, expected 0", adc_start_o); end
        if (dac_rdy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_dac_rdy: got %b, expected 0", dac_rdy_o); end
        if (dac_data_o !== 16'h0) begin failures++; $display("[TB] FAIL reset_dac_data: got %h, expected 0000", dac_data_o); end
        if (overrun_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun: got %b, expected 0", overrun_o); end
        if (timeout_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout: got %b, expected 0", timeout_o); end
        if (dut.r_state !== ST_IDLE) begin failures++; $display("[TB] FAIL reset_state: got %0d, expected %0d", dut.r_state, ST_IDLE); end
    endtask

    task automatic test_periodic();
        bit f;
        int t, t2, expT;
        adcRespond = 1'b1;
        expectDelivery = 1'b1;
        step();
        enable_i = 1'b1;
        expT = cyc + CLK_DIV;
        for (int k = 0; k < 3; k++) begin
            waitStart(CLK_DIV + 20, f, t);
            checks++;
            if (!f || t != expT) begin failures++; $display("[TB] FAIL start_period%0d: got cycle %0d, expected %0d", k, t, expT); end
            waitDacRdy(ADC_LAT + 20, f, t2);
            checks++;
            if (!f || t2 != t + ADC_LAT + 1) begin failures++; $display("[TB] FAIL rdy_latency%0d: got cycle %0d, expected %0d", k, t2, t + ADC_LAT + 1); end
            lastStart = t;
            expT = t + CLK_DIV;
        end
        checks += 2;
        if (overrun_o !== 1'b0) begin failures++; $display("[TB] FAIL periodic_overrun: got %b, expected 0", overrun_o); end
        if (timeout_o !== 1'b0) begin failures++; $display("[TB] FAIL periodic_timeout: got %b, expected 0", timeout_o); end
    endtask

    task automatic test_timeout();
        bit f;
        int s, t;
        adcRespond = 1'b0;
        waitStart(CLK_DIV + 20, f, s);
        checks++;
        if (!f || s != lastStart + CLK_DIV) begin failures++; $display("[TB] FAIL to_start: got cycle %0d, expected %0d", s, lastStart + CLK_DIV); end
        while (cyc < s + TIMEOUT) step();
        checks++;
        if (timeout_o !== 1'b0) begin failures++; $display("[TB] FAIL timeout_early: got %b, expected 0", timeout_o); end
        step();
        checks++;
        if (timeout_o !== 1'b1) begin failures++; $display("[TB] FAIL timeout_set: got %b, expected 1", timeout_o); end
        adcRespond = 1'b1;
        waitStart(CLK_DIV + 20, f, t);
        checks++;
        if (!f || t != s + CLK_DIV) begin failures++; $display("[TB] FAIL to_next_start: got cycle %0d, expected %0d", t, s + CLK_DIV); end
        lastStart = t;
        step();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        checks++;
        if (timeout_o !== 1'b0) begin failures++; $display("[TB] FAIL timeout_clear: got %b, expected 0", timeout_o); end
        waitDacRdy(ADC_LAT + 20, f, t);
        checks++;
        if (!f || t != lastStart + ADC_LAT + 1) begin failures++; $display("[TB] FAIL to_recover_rdy: got cycle %0d, expected %0d", t, lastStart + ADC_LAT + 1); end
    endtask

    task automatic test_busy();
        bit f;
        int s, t;
        waitStart(CLK_DIV + 20, f, s);
        checks++;
        if (!f || s != lastStart + CLK_DIV) begin failures++; $display("[TB] FAIL busy_start: got cycle %0d, expected %0d", s, lastStart + CLK_DIV); end
        dac_busy_i = 1'b1;
        while (cyc < s + CLK_DIV) step();
        checks++;
        if (dut.r_pend !== 1'b1) begin failures++; $display("[TB] FAIL busy_pend: got %b, expected 1", dut.r_pend); end
        while (cyc < s + 2 * CLK_DIV - 1) step();
        checks++;
        if (overrun_o !== 1'b0) begin failures++; $display("[TB] FAIL overrun_early: got %b, expected 0", overrun_o); end
        step();
        step();
        checks++;
        if (overrun_o !== 1'b1) begin failures++; $display("[TB] FAIL overrun_set: got %b, expected 1", overrun_o); end
        while (cyc < s + 250) step();
        dac_busy_i = 1'b0;
        waitDacRdy(5, f, t);
        checks++;
        if (!f || t != s + 251) begin failures++; $display("[TB] FAIL busy_release_rdy: got cycle %0d, expected %0d", t, s + 251); end
        waitStart(5, f, t);
        checks++;
        if (!f || t != s + 252) begin failures++; $display("[TB] FAIL pend_start: got cycle %0d, expected %0d", t, s + 252); end
        waitDacRdy(ADC_LAT + 20, f, t);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        checks++;
        if (overrun_o !== 1'b0) begin failures++; $display("[TB] FAIL overrun_clear: got %b, expected 0", overrun_o); end
        lastStart = s + 2 * CLK_DIV;
    endtask

    task automatic test_enable_drop();
        bit f;
        int s, t, r, rdyBefore;
        waitStart(CLK_DIV + 20, f, s);
        checks++;
        if (!f || s != lastStart + CLK_DIV) begin failures++; $display("[TB] FAIL en_start: got cycle %0d, expected %0d", s, lastStart + CLK_DIV); end
        expectDelivery = 1'b0;
        rdyBefore = rdySeen;
        while (cyc < s + 5) step();
        enable_i = 1'b0;
        while (cyc < s + ADC_LAT + 2) step();
        checks++;
        if (dut.r_state !== ST_IDLE) begin failures++; $display("[TB] FAIL en_idle: got state %0d, expected %0d", dut.r_state, ST_IDLE); end
        while (cyc < s + 30) step();
        checks++;
        if (rdySeen != rdyBefore) begin failures++; $display("[TB] FAIL en_late_rdy: got %0d strobes, expected 0", rdySeen - rdyBefore); end
        enable_i = 1'b1;
        r = cyc;
        expectDelivery = 1'b1;
        waitStart(CLK_DIV + 20, f, t);
        checks++;
        if (!f || t != r + CLK_DIV) begin failures++; $display("[TB] FAIL en_restart: got cycle %0d, expected %0d", t, r + CLK_DIV); end
        lastStart = t;
        waitDacRdy(ADC_LAT + 20, f, t);
    endtask

    task automatic test_reset_deliv();
        bit f;
        int s, rdyBefore;
        waitStart(CLK_DIV + 20, f, s);
        checks++;
        if (!f || s != lastStart + CLK_DIV) begin failures++; $display("[TB] FAIL rd_start: got cycle %0d, expected %0d", s, lastStart + CLK_DIV); end
        dac_busy_i = 1'b1;
        expectDelivery = 1'b0;
        while (cyc < s + 30) step();
        checks++;
        if (dut.r_state !== ST_DELIV) begin failures++; $display("[TB] FAIL rd_in_deliv: got state %0d, expected %0d", dut.r_state, ST_DELIV); end
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        checks += 4;
        if (dut.r_state !== ST_IDLE) begin failures++; $display("[TB] FAIL rd_state: got %0d, expected %0d", dut.r_state, ST_IDLE); end
        if (dac_data_o !== 16'h0) begin failures++; $display("[TB] FAIL rd_dac_data: got %h, expected 0000", dac_data_o); end
        if (dac_rdy_o !== 1'b0) begin failures++; $display("[TB] FAIL rd_dac_rdy: got %b, expected 0", dac_rdy_o); end
        if (adc_start_o !== 1'b0) begin failures++; $display("[TB] FAIL rd_start_out: got %b, expected 0", adc_start_o); end
        dac_busy_i = 1'b0;
        rdyBefore = rdySeen;
        repeat (60) step();
        checks++;
        if (rdySeen != rdyBefore) begin failures++; $display("[TB] FAIL rd_no_delivery: got %0d strobes, expected 0", rdySeen - rdyBefore); end
        expectDelivery = 1'b1;
    endtask

`ifdef CONV_SCHED_AVG_EN
    task automatic test_average();
        bit f;
        int t, startsBefore;
        adcValues = '{14'd100, 14'd101, 14'd102, 14'd104};
        expectDelivery = 1'b1;
        startsBefore = startSeen;
        step();
        enable_i = 1'b1;
        waitDacRdy(3 * CLK_DIV, f, t);
        checks += 2;
        if (!f || dac_data_o !== 16'd101) begin failures++; $display("[TB] FAIL avg_data: got %h, expected %h", dac_data_o, 16'd101); end
        if (startSeen - startsBefore != AVG_CNT) begin failures++; $display("[TB] FAIL avg_starts: got %0d, expected %0d", startSeen - startsBefore, AVG_CNT); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef CONV_SCHED_AVG_EN
        test_average();
`else
        test_periodic();
        test_timeout();
        test_busy();
        test_enable_drop();
        test_reset_deliv();
`endif
        repeat (3) step();
        checks++;
        if (expQ.size() != 0) begin failures++; $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
